// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU, one quotient bit per clock.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);
    localparam int CW = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2*DATA_W:0] w, w_nxt;
    logic [DATA_W-1:0] dvs, diff, q, r, a_mag, b_mag;
    logic [2*DATA_W-1:0] res;
    logic sa, sb, ge, last, go;
    always_comb begin
        a_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        b_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        go    = start_i && !annul_i;
        ge    = w[2*DATA_W:DATA_W] >= {1'b0, dvs};
        diff  = w[2*DATA_W-1:DATA_W] - dvs;
        // the trial difference is always below the divisor, so DATA_W bits hold it
        w_nxt = ge ? {diff, w[DATA_W-1:0], 1'b1} : {w[2*DATA_W-1:0], 1'b0};
        q     = (sa ^ sb) ? -w_nxt[DATA_W-1:0] : w_nxt[DATA_W-1:0];
        r     = sa ? -w_nxt[2*DATA_W:DATA_W+1] : w_nxt[2*DATA_W:DATA_W+1];
        last  = cnt == CW'(DATA_W - 1);
    end
    always_comb begin
        state_nxt = state;
        case (state)
            FREE:    state_nxt = go ? ((opdata2_i == '0) ? BYZERO : ON) : FREE;
            BYZERO:  state_nxt = annul_i ? FREE : END;
            ON:      state_nxt = annul_i ? FREE : (last ? END : ON);
            default: state_nxt = go ? END : FREE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FREE;
        else      state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            w        <= '0;
            dvs      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            res      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            if (state == FREE && go) begin
                cnt <= '0;
                w   <= {{DATA_W{1'b0}}, a_mag, 1'b0};
                dvs <= b_mag;
                sa  <= signed_div_i && opdata1_i[DATA_W-1];
                sb  <= signed_div_i && opdata2_i[DATA_W-1];
                res <= '0;
            end
            if (state == ON && !annul_i) begin
                w   <= w_nxt;
                cnt <= cnt + 1'b1;
                if (last) res <= {r, q};
            end
            ready_o  <= state == END && state_nxt == END;
            result_o <= (state == END && state_nxt == END) ? res : '0;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit latency, signed/unsigned results, annul and async reset.
module tb_div_unit;
    logic clk = 1'b0, rst = 1'b0, signed_div = 1'b0, start = 1'b0, annul = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [63:0] result;
    logic ready;
    int n_assert = 0, n_fail = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // drive a request at a negedge, count posedges until ready, then check hold behaviour
    task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input int exp_n);
        int n;
        @(negedge clk);
        signed_div = s; op1 = a; op2 = b; start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!ready && n < 60);
        chk({tag, "_latency"}, 64'(n), 64'(exp_n));
        chk({tag, "_result"}, result, exp_res);
        op1 = 32'hDEAD_BEEF; op2 = 32'h0000_0001;
        @(posedge clk); @(negedge clk);
        chk({tag, "_hold"}, {63'b0, ready}, 64'd1);
        chk({tag, "_hold_res"}, result, exp_res);
    endtask

    task automatic drop(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, "_drop_ready"}, {63'b0, ready}, 64'd0);
        chk({tag, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        int seen;
        #2;
        chk("reset_ready", {63'b0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk); rst = 1'b1;

        run("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        drop("u100_7");
        run("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 34);
        drop("s_m7_2");
        run("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'h2, 64'h00000001_7FFFFFFC, 34);
        drop("u_m7_2");
        run("div0", 1'b0, 32'h1234, 32'h0, 64'h0, 3);
        drop("div0");
        run("intmin_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        drop("intmin_m1");
        run("intmin_2", 1'b1, 32'h80000000, 32'h2, 64'h00000000_C0000000, 34);
        drop("intmin_2");
        run("u_big", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'h00000001_00000001, 34);
        drop("u_big");

        // annul after ten iterations; ready must never rise afterwards
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk); annul = 1'b1; start = 1'b0;
        @(posedge clk); @(negedge clk); annul = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (ready || result != 64'd0) seen++;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);
        drop("u9_3");

        // async reset mid-ON, then a clean 5/5
        @(negedge clk);
        op1 = 32'd77; op2 = 32'd4; start = 1'b1;
        repeat (6) @(posedge clk);
        #3 rst = 1'b0; start = 1'b0;
        #1;
        chk("rst_on_ready", {63'b0, ready}, 64'd0);
        chk("rst_on_result", result, 64'd0);
        @(negedge clk); rst = 1'b1;
        run("u5_5", 1'b0, 32'd5, 32'd5, 64'h00000000_00000001, 34);

        // async reset while a result is being presented
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_end_ready", {63'b0, ready}, 64'd0);
        chk("rst_end_result", result, 64'd0);
        @(negedge clk); start = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_ready", {63'b0, ready}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider for the EX stage; executes DIV/DIVU by restoring division, one quotient bit per clock.
- EX asserts `start_i` and raises its stall request to the pipeline controller until `ready_o` returns. The controller then emits stall = 6'b001111.
- `annul_i` is driven from the controller's flush output. An exception or ERET aborts an in-flight divide.

Parameters:
- DATA_W, 32, operand width. Quotient and remainder are each DATA_W bits; the iteration count equals DATA_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- signed_div_i  in  1  1 = signed DIV, 0 = unsigned DIVU; sampled at start.
- opdata1_i  in  DATA_W  dividend; sampled at start.
- opdata2_i  in  DATA_W  divisor; sampled at start.
- start_i  in  1  request a divide; held high by EX until the result is consumed.
- annul_i  in  1  abort the current operation (pipeline flush).
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  out  1  result_o valid; registered.

Behaviour:
- Reset (rst=0, async): state=FREE, cnt=0, internal regs=0, result_o=0, ready_o=0.
- States: FREE, BYZERO, ON, END (2-bit encoding).
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON, cnt=0.
  - Operand latch on entering ON: dividend/divisor magnitudes are latched. In signed mode with a negative operand, the two's-complement negation is latched instead. Sign flags for the dividend and divisor are also stored.
  - Otherwise stay FREE, ready_o=0, result_o=0.
- BYZERO: next edge -> END with quotient=0, remainder=0.
- ON: one iteration per edge.
  - Working register: 2*DATA_W+1 bits, initialised {0, dividend, 0}.
  - Each iteration: trial-subtract divisor from the upper DATA_W+1 bits.
    - Non-negative result: shift in quotient bit 1 and keep the difference.
    - Negative result: shift in 0 and restore.
  - cnt increments per edge. After cnt reaches DATA_W (32 iterations), -> END.
  - Result correction on entry to END (signed mode only):
    - Quotient is negated if the operand signs differed.
    - Remainder is negated if the dividend was negative.
  - annul_i=1 while in ON -> FREE on next edge; partial result discarded; ready_o stays 0.
- END:
  - ready_o=1, result_o holds the final value.
  - Stays in END while start_i=1.
  - start_i=0 -> FREE, ready_o=0, result_o=0.
  - annul_i=1 -> FREE as well.
- Latency: start sampled at edge E0; ready_o=1 after edge E0+33 (non-zero divisor) or E0+2 (zero divisor).
- start_i asserted while in BYZERO/ON/END is not a new request; operands are not re-sampled.
- Priority in every state: reset > annul_i > start_i.
- Arithmetic: INT_MIN / -1 signed gives quotient 0x80000000 (wraps), remainder 0. The magnitude 0x80000000 is treated as unsigned inside the datapath.
- Reset mid-operation: immediate return to FREE with all outputs 0. No partial result is ever presented.

Test Plan:
- Unsigned 100/7, start held -> ready_o rises 33 cycles after start; result_o=0x00000002_0000000E. Dropping start -> ready_o=0 and result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. Same operands unsigned -> quotient 0x7FFFFFFC, remainder 0x00000001.
- Divisor 0 (opdata1=0x1234) -> ready_o after 2 cycles, result_o=0.
- Signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000. 0x80000000 / 0x00000002 signed -> quotient 0xC0000000, remainder 0.
- annul_i pulsed at iteration 10 -> FREE next edge, ready_o never rises. A fresh start of 9/3 then yields 0x00000000_00000003 after 33 cycles.
- rst driven low asynchronously mid-ON (between clock edges) -> ready_o=0 and result_o=0 immediately. After release, a start of 5/5 completes with result_o=0x00000000_00000001.
